ddram_arb: RTL and testbench
============================

# ddram_arb

Two-port arbiter that shares the single DDRAM command/data port of `emu` between two requesters, e.g. a framebuffer/video reader (port 0) and a core-side loader or writer (port 1). It accepts one burst command per grant and holds ownership until that burst finishes. It routes write beats from the owner and read beats back to the owner. It sits between core logic and the `DDRAM_*` pins in `clk_sys`; `DDRAM_CLK` is driven outside this block.

## Interface
- `MAX_BURST`, default 8: largest burst accepted, 1..255; larger requests are clamped.
- `STARVE_LIMIT`, default 16: number of cycles port 1 may wait before it wins a simultaneous request.

Ports:
- `clk_sys` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cN_req` in 1 (N=0,1): command valid; held until `cN_ack`.
- `cN_we` in 1: 1=write burst, 0=read burst.
- `cN_addr` in 29: 64-bit-word address.
- `cN_burst` in 8: beat count; 0 is treated as 1.
- `cN_ack` out 1: one-cycle pulse, command latched.
- `cN_wdata` in 64, `cN_be` in 8: current write beat.
- `cN_wnext` out 1: current write beat consumed.
- `cN_rdata` out 64, `cN_rvalid` out 1: read beat returned to owner.
- `ddr_busy` in 1, `ddr_dout` in 64, `ddr_dout_ready` in 1: DDRAM side inputs.
- `ddr_burstcnt` out 8, `ddr_addr` out 29, `ddr_rd` out 1, `ddr_we` out 1, `ddr_din` out 64, `ddr_be` out 8: DDRAM side outputs.

## Operation
- States: IDLE, RD_CMD, RD_DATA, WR_DATA. Only one transaction is outstanding at a time.
- IDLE, arbitration:
  - Only one `cN_req` high: grant that port.
  - Both high: grant port 0, unless `starve_cnt == STARVE_LIMIT`, then grant port 1.
  - On grant, latch owner, `addr`, clamped `burst` and `we`; set the beat counter to 0.
  - Next state: WR_DATA if `we`, else RD_CMD.
- RD_CMD:
  - `ddr_rd=1` with the latched `ddr_addr`/`ddr_burstcnt`.
  - Held while `ddr_busy`; when `!ddr_busy`, go to RD_DATA.
- RD_DATA:
  - Each `ddr_dout_ready` raises the owner's `cN_rvalid` in the same cycle and increments the counter.
  - On the last beat, go to IDLE.
- WR_DATA:
  - `ddr_we=1`, `ddr_din`/`ddr_be` = the owner's `cN_wdata`/`cN_be` (combinational mux).
  - Owner's `cN_wnext = !ddr_busy`.
  - Each accepted beat increments the counter; on the last accepted beat, go to IDLE.
- `cN_rdata` always equals `ddr_dout`; only `cN_rvalid` is qualified.
- `starve_cnt` (width clog2(STARVE_LIMIT+1)):
  - Increments in every cycle where `c1_req` is high and port 1 is not being granted; saturates at `STARVE_LIMIT`.
  - Clears when port 1 is granted.
- `ddr_rd`/`ddr_we` are 0 in IDLE. `ddr_dout_ready` seen outside RD_DATA (stale beats after reset) is ignored.
- Clamp: `burst_eff = (burst==0) ? 1 : min(burst, MAX_BURST)`; the counter is 8 bits wide.

## Timing
- Reset (async assert, sync release):
  - State IDLE; latched addr/burst/owner = 0; `starve_cnt` = 0.
  - Outputs `cN_ack`, `cN_wnext`, `cN_rvalid`, `ddr_rd`, `ddr_we` = 0; `ddr_addr`, `ddr_burstcnt`, `ddr_din`, `ddr_be` = 0.
  - `cN_rdata` follows `ddr_dout`.
- Reset mid-burst abandons the transaction immediately; no further `cN_rvalid`/`cN_wnext` are issued.
- Latency from `cN_req` sampled at edge k in IDLE:
  - `cN_ack` is registered and high for exactly the cycle after edge k.
  - `ddr_rd` or `ddr_we` is first high in that same cycle.
- The requester must drop or change `cN_req` after the edge where it samples `cN_ack`; IDLE re-arbitrates no earlier than the cycle after the transaction's last beat.
- Write burst of B beats with `ddr_busy` low throughout: B cycles in WR_DATA, then 1 cycle in IDLE.
- Read burst: RD_CMD lasts ≥1 cycle; RD_DATA lasts until B `ddr_dout_ready` beats have been seen.
- `cN_wnext`, `cN_rvalid` and `ddr_din` are combinational from state plus inputs; all state is registered.

## Configuration
- `DDRAM_ARB_ROUNDROBIN_EN` defined:
  - Simultaneous requests are granted to the port not granted last; the last-grant register resets to port 1, so port 0 wins first.
  - `starve_cnt` is not implemented and `STARVE_LIMIT` is ignored.
- Undefined: fixed priority to port 0 with the `STARVE_LIMIT` escape described above.

## Test plan
- Single read: `c0_req` with `we=0`, `addr=0x100`, `burst=4`, `ddr_busy` low, 4 `ddr_dout_ready` beats → `c0_ack` once, `ddr_rd` one cycle with `ddr_addr=0x100`/`burstcnt=4`, exactly 4 `c0_rvalid`, and `c1_rvalid` never asserted.
- Write with backpressure: `c1` write, `burst=3`, `ddr_busy` high for 2 cycles mid-burst → exactly 3 `c1_wnext`, `ddr_din` matches each beat, return to IDLE.
- Starvation: both requesters continuously request 1-beat reads, fixed priority, `STARVE_LIMIT=16` → port 1 is granted after `starve_cnt` reaches 16, and the counter then clears. With `DDRAM_ARB_ROUNDROBIN_EN`, grants alternate 0,1,0,1.
- Clamp: `burst=0` → `ddr_burstcnt=1`. `burst=20` with `MAX_BURST=8` → `ddr_burstcnt=8` and 8 beats.
- Reset mid-read: assert `reset_n=0` after beat 2 of 8 → all outputs 0 asynchronously. After release, the late `ddr_dout_ready` beats produce no `cN_rvalid`, and a new request is acked normally.

Source files
------------

// File: rtl/ddram_arb_if.sv
// rtl/ddram_arb_if.sv - requester-side burst command/data port of ddram_arb
interface ddram_arb_if;
   logic        req;
   logic        we;
   logic [28:0] addr;
   logic [7:0]  burst;
   logic        ack;
   logic [63:0] wdata;
   logic [7:0]  be;
   logic        wnext;
   logic [63:0] rdata;
   logic        rvalid;

   modport master (
      output req, we, addr, burst, wdata, be,
      input  ack, wnext, rdata, rvalid
   );

   modport slave (
      input  req, we, addr, burst, wdata, be,
      output ack, wnext, rdata, rvalid
   );
endinterface

// File: rtl/ddram_arb.sv
// rtl/ddram_arb.sv - two-port DDRAM burst arbiter, one burst per grant
// DDRAM_ARB_ROUNDROBIN_EN selects round-robin instead of port-0 priority with starvation escape.
module ddram_arb #(
   parameter int MAX_BURST    = 8,
   parameter int STARVE_LIMIT = 16
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   ddram_arb_if.slave  c0,
   ddram_arb_if.slave  c1,
   input  logic        ddr_busy,
   input  logic [63:0] ddr_dout,
   input  logic        ddr_dout_ready,
   output logic [7:0]  ddr_burstcnt,
   output logic [28:0] ddr_addr,
   output logic        ddr_rd,
   output logic        ddr_we,
   output logic [63:0] ddr_din,
   output logic [7:0]  ddr_be
);
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_RD_CMD  = 2'd1;
   localparam logic [1:0] S_RD_DATA = 2'd2;
   localparam logic [1:0] S_WR_DATA = 2'd3;
   localparam logic [7:0] MAX_B     = 8'(MAX_BURST);

   logic [1:0]  state_q, state_d;
   logic        owner_q, owner_d;
   logic [28:0] addr_q, addr_d;
   logic [7:0]  burst_q, burst_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        ack0_q, ack0_d;
   logic        ack1_q, ack1_d;

   logic        idle;
   logic        grant0, grant1;
   logic [7:0]  req_burst, req_burst_eff;
   logic [7:0]  cnt_inc;
   logic        beat;

   assign idle = (state_q == S_IDLE);

`ifdef DDRAM_ARB_ROUNDROBIN_EN
   logic last_q, last_d;

   // On a tie, port 1 wins only if port 0 was granted last.
   assign grant1 = idle && c1.req && (!c0.req || !last_q);

   always_comb begin
      last_d = last_q;
      if (grant0 || grant1) last_d = grant1;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) last_q <= 1'b1;
      else          last_q <= last_d;
   end
`else
   localparam int            SW         = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   logic [SW-1:0] starve_q, starve_d;

   assign grant1 = idle && c1.req && (!c0.req || (starve_q == STARVE_MAX));

   always_comb begin
      starve_d = starve_q;
      if (grant1)                                starve_d = '0;
      else if (c1.req && (starve_q != STARVE_MAX)) starve_d = starve_q + 1'b1;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) starve_q <= '0;
      else          starve_q <= starve_d;
   end
`endif

   assign grant0 = idle && c0.req && !grant1;

   assign req_burst     = grant1 ? c1.burst : c0.burst;
   assign req_burst_eff = (req_burst == 8'd0)  ? 8'd1  :
                          (req_burst > MAX_B)  ? MAX_B : req_burst;

   assign beat    = ((state_q == S_RD_DATA) && ddr_dout_ready) ||
                    ((state_q == S_WR_DATA) && !ddr_busy);
   assign cnt_inc = cnt_q + 8'd1;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      addr_d  = addr_q;
      burst_d = burst_q;
      cnt_d   = cnt_q;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (grant0 || grant1) begin
               owner_d = grant1;
               addr_d  = grant1 ? c1.addr : c0.addr;
               burst_d = req_burst_eff;
               cnt_d   = 8'd0;
               ack0_d  = grant0;
               ack1_d  = grant1;
               state_d = (grant1 ? c1.we : c0.we) ? S_WR_DATA : S_RD_CMD;
            end
         end
         S_RD_CMD: begin
            if (!ddr_busy) state_d = S_RD_DATA;
         end
         default: begin
            if (beat) begin
               cnt_d = cnt_inc;
               if (cnt_inc == burst_q) state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         owner_q <= 1'b0;
         addr_q  <= '0;
         burst_q <= '0;
         cnt_q   <= '0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         addr_q  <= addr_d;
         burst_q <= burst_d;
         cnt_q   <= cnt_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
      end
   end

   assign ddr_rd       = (state_q == S_RD_CMD);
   assign ddr_we       = (state_q == S_WR_DATA);
   assign ddr_addr     = addr_q;
   assign ddr_burstcnt = burst_q;
   assign ddr_din      = ddr_we ? (owner_q ? c1.wdata : c0.wdata) : 64'd0;
   assign ddr_be       = ddr_we ? (owner_q ? c1.be    : c0.be)    : 8'd0;

   assign c0.ack    = ack0_q;
   assign c1.ack    = ack1_q;
   assign c0.wnext  = ddr_we && !owner_q && !ddr_busy;
   assign c1.wnext  = ddr_we &&  owner_q && !ddr_busy;
   // Read data is broadcast; only the valid strobe is steered to the owner.
   assign c0.rdata  = ddr_dout;
   assign c1.rdata  = ddr_dout;
   assign c0.rvalid = (state_q == S_RD_DATA) && ddr_dout_ready && !owner_q;
   assign c1.rvalid = (state_q == S_RD_DATA) && ddr_dout_ready &&  owner_q;
endmodule

// File: tb/tb_ddram_arb.sv
// tb/tb_ddram_arb.sv - scoreboard bench for ddram_arb
module tb_ddram_arb;
   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        ddr_busy = 1'b0;
   logic [63:0] ddr_dout = '0;
   logic        ddr_dout_ready = 1'b0;
   logic [7:0]  ddr_burstcnt;
   logic [28:0] ddr_addr;
   logic        ddr_rd, ddr_we;
   logic [63:0] ddr_din;
   logic [7:0]  ddr_be;

   ddram_arb_if c0_if ();
   ddram_arb_if c1_if ();

   ddram_arb dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .c0(c0_if), .c1(c1_if),
      .ddr_busy(ddr_busy), .ddr_dout(ddr_dout), .ddr_dout_ready(ddr_dout_ready),
      .ddr_burstcnt(ddr_burstcnt), .ddr_addr(ddr_addr), .ddr_rd(ddr_rd),
      .ddr_we(ddr_we), .ddr_din(ddr_din), .ddr_be(ddr_be)
   );

   always #5 clk_sys = ~clk_sys;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [63:0] rv0_q[$];
   logic [63:0] rv1_q[$];
   logic [71:0] wn1_q[$];
   logic [36:0] cmd_q[$];
   int          ack_q[$];
   int          wn0_cnt = 0;
   int          rdcyc = 0;
   int          wecyc = 0;

   always @(negedge clk_sys) begin
      if (c0_if.rvalid) rv0_q.push_back(c0_if.rdata);
      if (c1_if.rvalid) rv1_q.push_back(c1_if.rdata);
      if (c0_if.ack) ack_q.push_back(0);
      if (c1_if.ack) ack_q.push_back(1);
      if (c0_if.wnext) wn0_cnt++;
      if (c1_if.wnext) wn1_q.push_back({ddr_din, ddr_be});
      if (ddr_rd) begin
         rdcyc++;
         cmd_q.push_back({ddr_addr, ddr_burstcnt});
      end
      if (ddr_we) wecyc++;
   end

   task automatic clear_obs();
      rv0_q.delete(); rv1_q.delete(); wn1_q.delete(); cmd_q.delete(); ack_q.delete();
      wn0_cnt = 0; rdcyc = 0; wecyc = 0;
   endtask

   function automatic logic [63:0] beat_data(input int port, input int i);
      return 64'hD00D_0000_0000_0000 | (64'(port) << 32) | 64'(i * 3 + 1);
   endfunction

   task automatic apply_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      ddr_dout = 64'hA5A5_5A5A_0123_4567;
      ddr_dout_ready = 1'b1;
      apply_reset();
      @(negedge clk_sys); #1;
      total_cnt++;
      if ({ddr_rd, ddr_we, c0_if.ack, c1_if.ack} !== 4'b0)
         $display("FAIL reset_ctrl got=%b exp=0000", {ddr_rd, ddr_we, c0_if.ack, c1_if.ack});
      else pass_cnt++;
      total_cnt++;
      if ({c0_if.rvalid, c1_if.rvalid, c0_if.wnext, c1_if.wnext} !== 4'b0)
         $display("FAIL reset_strobes got=%b exp=0000", {c0_if.rvalid, c1_if.rvalid, c0_if.wnext, c1_if.wnext});
      else pass_cnt++;
      total_cnt++;
      if ({ddr_addr, ddr_burstcnt, ddr_din, ddr_be} !== 109'd0)
         $display("FAIL reset_bus got=%h exp=0", {ddr_addr, ddr_burstcnt, ddr_din, ddr_be});
      else pass_cnt++;
      total_cnt++;
      if (c1_if.rdata !== 64'hA5A5_5A5A_0123_4567)
         $display("FAIL reset_rdata got=%h exp=%h", c1_if.rdata, 64'hA5A5_5A5A_0123_4567);
      else pass_cnt++;
      @(posedge clk_sys); #1;
      ddr_dout_ready = 1'b0;
   endtask

   // Issues one read on a port, supplies beats on alternate cycles, then scores the result.
   task automatic do_read(input int port, input logic [28:0] addr, input logic [7:0] burst,
                          input int supply, input int exp_cnt, input string name);
      logic [63:0] exp_q[$];
      logic        ackd;
      int          given = 0;
      logic [63:0] got;
      logic [63:0] want;
      int          other_cnt;
      int          own_cnt;
      clear_obs();
      @(posedge clk_sys); #1;
      if (port == 0) begin
         c0_if.req = 1'b1; c0_if.we = 1'b0; c0_if.addr = addr; c0_if.burst = burst;
      end else begin
         c1_if.req = 1'b1; c1_if.we = 1'b0; c1_if.addr = addr; c1_if.burst = burst;
      end
      for (int c = 0; c < 60; c++) begin
         @(negedge clk_sys);
         ackd = (port == 0) ? c0_if.ack : c1_if.ack;
         @(posedge clk_sys); #1;
         if (ackd) begin
            if (port == 0) c0_if.req = 1'b0; else c1_if.req = 1'b0;
         end
         ddr_dout_ready = 1'b0;
         if (rdcyc > 0 && given < supply && c[0]) begin
            ddr_dout_ready = 1'b1;
            ddr_dout = beat_data(port, given);
            if (given < exp_cnt) exp_q.push_back(ddr_dout);
            given++;
         end
      end
      @(negedge clk_sys); #1;
      total_cnt++;
      if (ack_q.size() !== 1 || ack_q[0] !== port)
         $display("FAIL %s_ack got_n=%0d exp_n=1 port=%0d", name, ack_q.size(), port);
      else pass_cnt++;
      total_cnt++;
      if (cmd_q.size() !== 1 || cmd_q[0] !== {addr, 8'(exp_cnt)})
         $display("FAIL %s_cmd got_n=%0d got=%h exp=%h", name, cmd_q.size(),
                  (cmd_q.size() > 0) ? cmd_q[0] : 37'd0, {addr, 8'(exp_cnt)});
      else pass_cnt++;
      own_cnt   = (port == 0) ? rv0_q.size() : rv1_q.size();
      other_cnt = (port == 0) ? rv1_q.size() : rv0_q.size();
      total_cnt++;
      if (own_cnt !== exp_cnt || other_cnt !== 0)
         $display("FAIL %s_rvalid got=%0d/%0d exp=%0d/0", name, own_cnt, other_cnt, exp_cnt);
      else pass_cnt++;
      while (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         if (port == 0) got = (rv0_q.size() > 0) ? rv0_q.pop_front() : 64'hX;
         else           got = (rv1_q.size() > 0) ? rv1_q.pop_front() : 64'hX;
         total_cnt++;
         if (got !== want) $display("FAIL %s_data got=%h exp=%h", name, got, want);
         else pass_cnt++;
      end
   endtask

   task automatic test_single_read();
      do_read(0, 29'h100, 8'd4, 4, 4, "single_read");
   endtask

   task automatic test_write_backpressure();
      logic [63:0] wdat[3] = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC};
      logic [7:0]  wbe[3]  = '{8'hFF, 8'h0F, 8'hA5};
      logic [71:0] exp_q[$];
      logic [71:0] got;
      logic [71:0] want;
      logic        ackd;
      logic        wn;
      int          idx = 0;
      clear_obs();
      for (int i = 0; i < 3; i++) exp_q.push_back({wdat[i], wbe[i]});
      @(posedge clk_sys); #1;
      c1_if.req = 1'b1; c1_if.we = 1'b1; c1_if.addr = 29'h3000; c1_if.burst = 8'd3;
      c1_if.wdata = wdat[0]; c1_if.be = wbe[0];
      for (int c = 0; c < 30; c++) begin
         @(negedge clk_sys);
         ackd = c1_if.ack;
         wn   = c1_if.wnext;
         if (wn) idx++;
         @(posedge clk_sys); #1;
         if (ackd) c1_if.req = 1'b0;
         if (idx < 3) begin
            c1_if.wdata = wdat[idx]; c1_if.be = wbe[idx];
         end
         ddr_busy = (wecyc == 1 || wecyc == 2);
      end
      ddr_busy = 1'b0;
      @(negedge clk_sys); #1;
      total_cnt++;
      if (wn1_q.size() !== 3 || wn0_cnt !== 0)
         $display("FAIL wr_wnext got=%0d/%0d exp=3/0", wn1_q.size(), wn0_cnt);
      else pass_cnt++;
      total_cnt++;
      if (wecyc !== 5) $display("FAIL wr_we_cycles got=%0d exp=5", wecyc);
      else pass_cnt++;
      total_cnt++;
      if (ddr_we !== 1'b0 || ddr_din !== 64'd0)
         $display("FAIL wr_idle got_we=%b got_din=%h exp=0", ddr_we, ddr_din);
      else pass_cnt++;
      while (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         got  = (wn1_q.size() > 0) ? wn1_q.pop_front() : 72'hX;
         total_cnt++;
         if (got !== want) $display("FAIL wr_beat got=%h exp=%h", got, want);
         else pass_cnt++;
      end
   endtask

   task automatic test_clamp();
      do_read(0, 29'h10, 8'd0, 1, 1, "clamp_zero");
      do_read(1, 29'h1FFF_FFFF, 8'd20, 10, 8, "clamp_max");
   endtask

   task automatic test_starvation();
      int exp_q[$];
      int want;
      apply_reset();
      clear_obs();
`ifdef DDRAM_ARB_ROUNDROBIN_EN
      for (int i = 0; i < 13; i++) exp_q.push_back(i % 2);
`else
      for (int i = 0; i < 6; i++) exp_q.push_back(0);
      exp_q.push_back(1);
      for (int i = 0; i < 5; i++) exp_q.push_back(0);
      exp_q.push_back(1);
`endif
      @(posedge clk_sys); #1;
      ddr_busy = 1'b0;
      ddr_dout_ready = 1'b1;
      c0_if.we = 1'b0; c0_if.burst = 8'd1; c0_if.addr = 29'h20;
      c1_if.we = 1'b0; c1_if.burst = 8'd1; c1_if.addr = 29'h21;
      c0_if.req = 1'b1; c1_if.req = 1'b1;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk_sys); #1;
         if (ack_q.size() >= 13) break;
      end
      c0_if.req = 1'b0; c1_if.req = 1'b0;
      repeat (6) @(posedge clk_sys);
      #1 ddr_dout_ready = 1'b0;
      total_cnt++;
      if (ack_q.size() < 13) $display("FAIL starve_grants got=%0d exp>=13", ack_q.size());
      else pass_cnt++;
      for (int i = 0; i < 13; i++) begin
         want = exp_q.pop_front();
         total_cnt++;
         if (i >= ack_q.size()) $display("FAIL starve_grant%0d got=none exp=%0d", i, want);
         else if (ack_q[i] !== want) $display("FAIL starve_grant%0d got=%0d exp=%0d", i, ack_q[i], want);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid_read();
      logic ackd;
      int   given = 0;
      clear_obs();
      @(posedge clk_sys); #1;
      c0_if.req = 1'b1; c0_if.we = 1'b0; c0_if.addr = 29'h200; c0_if.burst = 8'd8;
      for (int c = 0; c < 40 && given < 2; c++) begin
         @(negedge clk_sys);
         ackd = c0_if.ack;
         @(posedge clk_sys); #1;
         if (ackd) c0_if.req = 1'b0;
         ddr_dout_ready = 1'b0;
         if (rdcyc > 0) begin
            ddr_dout_ready = 1'b1;
            ddr_dout = beat_data(0, given);
            given++;
         end
      end
      @(negedge clk_sys); #1;
      total_cnt++;
      if (rv0_q.size() !== 2) $display("FAIL mid_beats got=%0d exp=2", rv0_q.size());
      else pass_cnt++;
      @(posedge clk_sys); #1;
      ddr_dout_ready = 1'b1;
      ddr_dout = beat_data(0, 2);
      #2 reset_n = 1'b0;
      #1;
      total_cnt++;
      if ({ddr_rd, ddr_we, c0_if.ack, c1_if.ack, c0_if.rvalid, c1_if.rvalid, c0_if.wnext, c1_if.wnext} !== 8'b0)
         $display("FAIL mid_async_ctrl got=%b exp=0", {ddr_rd, ddr_we, c0_if.ack, c1_if.ack,
                  c0_if.rvalid, c1_if.rvalid, c0_if.wnext, c1_if.wnext});
      else pass_cnt++;
      total_cnt++;
      if ({ddr_addr, ddr_burstcnt, ddr_din, ddr_be} !== 109'd0)
         $display("FAIL mid_async_bus got=%h exp=0", {ddr_addr, ddr_burstcnt, ddr_din, ddr_be});
      else pass_cnt++;
      clear_obs();
      repeat (2) @(posedge clk_sys);
      @(negedge clk_sys);
      reset_n = 1'b1;
      for (int i = 3; i < 8; i++) begin
         @(posedge clk_sys); #1;
         ddr_dout = beat_data(0, i);
      end
      ddr_dout_ready = 1'b0;
      @(negedge clk_sys); #1;
      total_cnt++;
      if (rv0_q.size() !== 0 || rv1_q.size() !== 0 || ack_q.size() !== 0)
         $display("FAIL mid_stale got=%0d/%0d/%0d exp=0/0/0", rv0_q.size(), rv1_q.size(), ack_q.size());
      else pass_cnt++;
      do_read(1, 29'h40, 8'd2, 2, 2, "after_reset");
   endtask

   initial begin
      c0_if.req = 1'b0; c0_if.we = 1'b0; c0_if.addr = '0; c0_if.burst = '0;
      c0_if.wdata = '0; c0_if.be = '0;
      c1_if.req = 1'b0; c1_if.we = 1'b0; c1_if.addr = '0; c1_if.burst = '0;
      c1_if.wdata = '0; c1_if.be = '0;
      test_reset();
      test_single_read();
      test_write_backpressure();
      test_clamp();
      test_starvation();
      test_reset_mid_read();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end
endmodule
